// File: rtl/sd_sector_buffer_if.sv
// sd_sector_buffer_if: host-side write and read byte streams of the sector buffer
interface sd_sector_buffer_if;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       rd_ready;
  modport master (output wr_valid, wr_data, rd_ready, input wr_ready, rd_valid, rd_data);
  modport slave  (input wr_valid, wr_data, rd_ready, output wr_ready, rd_valid, rd_data);
endinterface

// File: rtl/sd_sector_buffer.sv
// sd_sector_buffer: one-sector byte buffer between host streams and the SD controller; SD_BUF_CRC16_EN adds the data CRC16
module sd_sector_buffer #(
  parameter int SECTOR_BYTES = 512,
  parameter int CNT_W        = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 mode,
  input  logic                 ctrl_byte_strobe,
  input  logic                 ctrl_sector_done,
  input  logic [7:0]           ctrl_in_byte,
  output logic [7:0]           ctrl_out_byte,
  output logic                 sector_ready,
  sd_sector_buffer_if.slave    host,
  output logic [CNT_W-1:0]     byte_count,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow_err,
  output logic                 short_err,
  output logic [15:0]          crc16
);
  localparam int AW = $clog2(SECTOR_BYTES);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(SECTOR_BYTES);
  localparam logic [CNT_W-1:0] LAST = FULL - 1'b1;
  typedef enum logic [2:0] {IDLE, RX_FILL, RX_DRAIN, TX_LOAD, TX_SEND} state_t;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic             ovf_q, ovf_d, short_q, short_d, rdv_q, rdv_d, srdy_q, srdy_d, done_q, done_d;
  logic             store, start_ok;
  logic [7:0]       store_byte, rdata_q;
  logic [7:0]       mem [SECTOR_BYTES];
  assign start_ok   = start && state_q == IDLE;
  assign store_byte = state_q == TX_LOAD ? host.wr_data : ctrl_in_byte;
  // Next-state, pointer, count and flag logic; the write pointer is the fill count itself.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rptr_d  = rptr_q;
    ovf_d   = ovf_q;
    short_d = short_q;
    rdv_d   = rdv_q;
    srdy_d  = srdy_q;
    done_d  = 1'b0;
    store   = 1'b0;
    case (state_q)
      IDLE: if (start_ok) begin
        state_d = mode ? TX_LOAD : RX_FILL;
        cnt_d   = '0;
        rptr_d  = '0;
        ovf_d   = 1'b0;
        short_d = 1'b0;
      end
      RX_FILL: begin
        if (ctrl_byte_strobe) begin
          if (cnt_q == FULL) ovf_d = 1'b1;
          else begin
            store = 1'b1;
            cnt_d = cnt_q + 1'b1;
          end
        end
        if (ctrl_sector_done) begin
          state_d = RX_DRAIN;
          rptr_d  = '0;
          short_d = short_q | (cnt_d != FULL);
        end
      end
      RX_DRAIN: begin
        if (!rdv_q) begin
          if (cnt_q == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else rdv_d = 1'b1;
        end else if (host.rd_ready) begin
          rptr_d = rptr_q + 1'b1;
          cnt_d  = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
            rdv_d   = 1'b0;
          end
        end
      end
      TX_LOAD: if (host.wr_valid) begin
        store = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = TX_SEND;
          rptr_d  = '0;
          srdy_d  = 1'b1;
        end
      end
      TX_SEND: begin
        if (ctrl_byte_strobe) begin
          if (cnt_q == '0) ovf_d = 1'b1;
          else begin
            rptr_d = rptr_q + 1'b1;
            cnt_d  = cnt_q - 1'b1;
          end
        end
        if (ctrl_sector_done) begin
          state_d = IDLE;
          done_d  = 1'b1;
          srdy_d  = 1'b0;
          short_d = short_q | (cnt_d != '0);
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // Control registers; reset discards any op in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rptr_q  <= '0;
      ovf_q   <= 1'b0;
      short_q <= 1'b0;
      rdv_q   <= 1'b0;
      srdy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rptr_q  <= rptr_d;
      ovf_q   <= ovf_d;
      short_q <= short_d;
      rdv_q   <= rdv_d;
      srdy_q  <= srdy_d;
      done_q  <= done_d;
    end
  end
  // Sector storage written at the fill count.
  always_ff @(posedge clk) begin
    if (store) mem[cnt_q[AW-1:0]] <= store_byte;
  end
  // Prefetch register follows the next read pointer so data is ready one cycle ahead.
  always_ff @(posedge clk) begin
    if (rst) rdata_q <= '0;
    else rdata_q <= mem[rptr_d];
  end
`ifdef SD_BUF_CRC16_EN
  logic [15:0] crc_q, crc_d;
  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) r = {r[14:0], 1'b0} ^ ((r[15] ^ b[i]) ? 16'h1021 : 16'h0000);
    return r;
  endfunction
  // CRC cleared at op start, folded with each stored byte.
  always_comb crc_d = start_ok ? 16'h0000 : store ? crc_step(crc_q, store_byte) : crc_q;
  // CRC register.
  always_ff @(posedge clk) begin
    if (rst) crc_q <= '0;
    else crc_q <= crc_d;
  end
  assign crc16 = crc_q;
`else
  assign crc16 = 16'h0000;
`endif
  assign ctrl_out_byte = state_q != TX_SEND ? 8'h00 : cnt_q == '0 ? 8'hFF : rdata_q;
  assign sector_ready  = srdy_q;
  assign host.wr_ready = state_q == TX_LOAD;
  assign host.rd_valid = rdv_q;
  assign host.rd_data  = rdata_q;
  assign byte_count    = cnt_q;
  assign busy          = state_q != IDLE;
  assign done          = done_q;
  assign overflow_err  = ovf_q;
  assign short_err     = short_q;
endmodule
